p2s_sda_tx: RTL and testbench

P2S_SDA_TX -- requirements
Module: p2s_sda_tx

---
 rtl/p2s_sda_tx.sv | 151 +++++++++++++++
 tb/tb_p2s_sda_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/p2s_sda_tx.sv
// p2s_sda_tx: shifts a 4-bit word out MSB first as a start / data / stop frame on scl and sda.
// Define P2S_TXBUF_EN to add a one-entry holding buffer so frames can run back to back.
module p2s_sda_tx #(
   parameter int HALF = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] data,
   input  logic       req,
   output logic       rdy,
   output logic       scl,
   output logic       sda,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      BITLO,
      BITHI,
      STOPLO,
      STOPHI,
      RELEASE
   } state_t;

   localparam logic [7:0] PHASE_LAST = 8'(HALF - 1);

   state_t     state_q, state_d;
   logic [7:0] phase_q, phase_d;
   logic [1:0] bitIdx_q, bitIdx_d;
   logic [3:0] word_q, word_d;
   logic       scl_q, scl_d;
   logic       sda_q, sda_d;
   logic       phaseEnd;
   logic       frameEnd;
   logic       accept;
   logic       loadBuf;

`ifdef P2S_TXBUF_EN
   logic [3:0] hold_q, hold_d;
   logic       holdFull_q, holdFull_d;
`endif

   assign phaseEnd = (phase_q == PHASE_LAST);
   assign frameEnd = (state_q == RELEASE) && phaseEnd;
   assign accept   = req && rdy;
   assign busy     = (state_q != IDLE);
   assign done     = frameEnd;
   assign scl      = scl_q;
   assign sda      = sda_q;

`ifdef P2S_TXBUF_EN
   assign rdy     = !holdFull_q;
   // A parked word launches out of RELEASE, or from IDLE when it was taken on the done cycle.
   assign loadBuf = holdFull_q && (frameEnd || (state_q == IDLE));
`else
   assign rdy     = !busy;
   assign loadBuf = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         phase_q  <= '0;
         bitIdx_q <= 2'd3;
         word_q   <= '0;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
`ifdef P2S_TXBUF_EN
         hold_q     <= '0;
         holdFull_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         bitIdx_q <= bitIdx_d;
         word_q   <= word_d;
         scl_q    <= scl_d;
         sda_q    <= sda_d;
`ifdef P2S_TXBUF_EN
         hold_q     <= hold_d;
         holdFull_q <= holdFull_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (loadBuf || accept) state_d = START;
         START:   if (phaseEnd) state_d = BITLO;
         BITLO:   if (phaseEnd) state_d = BITHI;
         BITHI:   if (phaseEnd) state_d = (bitIdx_q == 2'd0) ? STOPLO : BITLO;
         STOPLO:  if (phaseEnd) state_d = STOPHI;
         STOPHI:  if (phaseEnd) state_d = RELEASE;
         RELEASE: if (phaseEnd) state_d = loadBuf ? START : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Phase timer, bit pointer, and the word being shifted (plus the parked word when buffered).
   always_comb begin
      phase_d  = phase_q + 8'd1;
      bitIdx_d = bitIdx_q;
      word_d   = word_q;
      if ((state_d != state_q) || (state_q == IDLE)) begin
         phase_d = '0;
      end
      if ((state_q == BITHI) && (state_d == BITLO)) begin
         bitIdx_d = bitIdx_q - 2'd1;
      end else if ((state_d == START) || (state_d == IDLE)) begin
         bitIdx_d = 2'd3;
      end
`ifdef P2S_TXBUF_EN
      hold_d     = hold_q;
      holdFull_d = holdFull_q;
      if (loadBuf) begin
         word_d     = hold_q;
         holdFull_d = 1'b0;
      end else if (accept && (state_q == IDLE)) begin
         word_d = data;
      end
      if (accept && (state_q != IDLE)) begin
         hold_d     = data;
         holdFull_d = 1'b1;
      end
`else
      if (accept && (state_q == IDLE)) begin
         word_d = data;
      end
`endif
   end

   // Line levels are decoded from the upcoming state so the registered pins track the FSM exactly.
   always_comb begin
      scl_d = 1'b1;
      sda_d = 1'b1;
      unique case (state_d)
         IDLE:    begin scl_d = 1'b1; sda_d = 1'b1; end
         START:   begin scl_d = 1'b1; sda_d = 1'b0; end
         BITLO:   begin scl_d = 1'b0; sda_d = word_d[bitIdx_d]; end
         BITHI:   begin scl_d = 1'b1; sda_d = word_d[bitIdx_d]; end
         STOPLO:  begin scl_d = 1'b0; sda_d = 1'b0; end
         STOPHI:  begin scl_d = 1'b1; sda_d = 1'b0; end
         RELEASE: begin scl_d = 1'b1; sda_d = 1'b1; end
         default: begin scl_d = 1'b1; sda_d = 1'b1; end
      endcase
   end

endmodule

// File: tb/tb_p2s_sda_tx.sv
// tb_p2s_sda_tx: frame-offset reference model plus a far-end receiver; compares p2s_sda_tx every cycle.
// Build with P2S_TXBUF_EN defined to exercise the holding-buffer scenario instead of the plain one.
module tb_p2s_sda_tx;

   localparam int HALF  = 4;
   localparam int FRAME = 12 * HALF;

   logic       clk = 1'b0;
   logic       rst;
   logic       req;
   logic [3:0] data;
   logic       rdy;
   logic       scl;
   logic       sda;
   logic       busy;
   logic       done;

   always #5 clk = ~clk;

   p2s_sda_tx #(.HALF(HALF)) dut (
      .clk  (clk),
      .rst  (rst),
      .data (data),
      .req  (req),
      .rdy  (rdy),
      .scl  (scl),
      .sda  (sda),
      .busy (busy),
      .done (done)
   );

   int assertCount = 0;
   int failCount   = 0;

   // Model: k is the cycle offset inside the current frame (-1 when idle), pend holds accepted words.
   int         k = -1;
   logic [3:0] cur = 4'h0;
   logic [3:0] pend[$];

   // Far-end receiver bookkeeping.
   int         cycleNo = 0;
   int         starts = 0, stops = 0, dones = 0, rises = 0, highOnes = 0;
   int         startCyc = 0, stopCyc = 0, lastGap = 0, doneOffset = 0;
   logic       sclPrev = 1'b1, sdaPrev = 1'b1, inFrame = 1'b0;
   logic [4:0] rxShift = '0;
   logic [3:0] lastRx = '0, prevRx = '0;

   function automatic logic [1:0] busLine(int kk, logic [3:0] w);
      int   p;
      int   b;
      logic hi;
      if (kk < 0) return 2'b11;
      p = kk / HALF;
      if (p == 0) return 2'b10;
      if (p <= 8) begin
         b  = 3 - (p - 1) / 2;
         hi = ((p - 1) % 2) == 1;
         return {hi, w[b]};
      end
      if (p == 9) return 2'b00;
      if (p == 10) return 2'b10;
      return 2'b11;
   endfunction

   function automatic logic modelRdy();
`ifdef P2S_TXBUF_EN
      return pend.size() == 0;
`else
      return k < 0;
`endif
   endfunction

   function automatic logic [15:0] rxOneHot(logic [3:0] w);
      logic [3:0] sh;
      sh = w - 4'd1;
      return 16'h0001 << sh;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleNo);
      end
   endtask

   // One clock: drive inputs, advance the model on the edge, then compare and feed the receiver.
   task automatic applyStimulus(input logic r, input logic q, input logic [3:0] d);
      logic       acc;
      logic [1:0] expLine;
      rst  = r;
      req  = q;
      data = d;
      @(posedge clk);
      acc = q && modelRdy();
      if (r) begin
         k = -1;
         pend.delete();
      end else if (k >= 0) begin
         if (k == FRAME - 1) begin
            if (pend.size() > 0) begin
               cur = pend.pop_front();
               k   = 0;
            end else begin
               k = -1;
            end
         end else begin
            k++;
         end
         if (acc) pend.push_back(d);
      end else if (pend.size() > 0) begin
         cur = pend.pop_front();
         k   = 0;
      end else if (acc) begin
         cur = d;
         k   = 0;
      end
      @(negedge clk);
      cycleNo++;
      expLine = busLine(k, cur);
      checkOutput("scl",  scl,  expLine[1]);
      checkOutput("sda",  sda,  expLine[0]);
      checkOutput("busy", busy, k >= 0);
      checkOutput("done", done, k == FRAME - 1);
      checkOutput("rdy",  rdy,  modelRdy());
      if (sclPrev && scl && sdaPrev && !sda) begin
         starts++;
         lastGap  = cycleNo - stopCyc;
         startCyc = cycleNo;
         rxShift  = '0;
         rises    = 0;
         highOnes = 0;
         inFrame  = 1'b1;
      end else if (sclPrev && scl && !sdaPrev && sda) begin
         stops++;
         stopCyc = cycleNo;
         prevRx  = lastRx;
         lastRx  = rxShift[4:1];
         inFrame = 1'b0;
      end
      if (!sclPrev && scl) begin
         rxShift = {rxShift[3:0], sda};
         rises++;
      end
      if (inFrame && sda) highOnes++;
      if (done) begin
         dones++;
         doneOffset = cycleNo - startCyc + 1;
      end
      sclPrev = scl;
      sdaPrev = sda;
   endtask

   task automatic sendWord(input logic [3:0] w);
      applyStimulus(1'b0, 1'b1, w);
      for (int i = 0; i < FRAME + 2; i++) applyStimulus(1'b0, 1'b0, ~w);
   endtask

   initial begin
      int s0, p0, d0;
      logic [15:0] expHot;

      applyStimulus(1'b1, 1'b0, 4'h0);
      applyStimulus(1'b1, 1'b0, 4'h0);
      checkOutput("reset_scl",  scl,  1);
      checkOutput("reset_sda",  sda,  1);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_rdy",  rdy,  1);

      // 1010: start, bits 1,0,1,0 on the rising clocks, stop, done on the 48th frame cycle.
      s0 = starts; p0 = stops;
      sendWord(4'b1010);
      checkOutput("f1010_starts", starts - s0, 1);
      checkOutput("f1010_stops",  stops - p0,  1);
      // four data clocks plus the clock that precedes the stop
      checkOutput("f1010_scl_rises", rises, 5);
      checkOutput("f1010_rx_bits", lastRx, 4'b1010);
      checkOutput("f1010_done_at", doneOffset, 48);
      checkOutput("f1010_onehot", rxOneHot(lastRx), 16'h0200);

      s0 = starts; p0 = stops;
      sendWord(4'b0000);
      checkOutput("f0000_starts", starts - s0, 1);
      checkOutput("f0000_stops",  stops - p0,  1);
      checkOutput("f0000_sda_high_cycles", highOnes, 0);
      checkOutput("f0000_onehot", rxOneHot(lastRx), 16'h8000);

      s0 = starts; p0 = stops;
      sendWord(4'b1111);
      checkOutput("f1111_starts", starts - s0, 1);
      checkOutput("f1111_stops",  stops - p0,  1);
      checkOutput("f1111_sda_high_cycles", highOnes, 32);
      checkOutput("f1111_onehot", rxOneHot(lastRx), 16'h4000);

      for (int v = 0; v < 16; v++) begin
         sendWord(4'(v));
         expHot = (v == 0) ? 16'h8000 : (16'h0001 << (v - 1));
         checkOutput("loop_onehot", rxOneHot(lastRx), expHot);
      end
      checkOutput("loop_onehot_v1", rxOneHot(4'd1), 16'h0001);

      // Abort in BITHI with index 1 (sda low there), with req also high on the reset cycle.
      applyStimulus(1'b0, 1'b1, 4'b0101);
      for (int i = 0; i < 6 * HALF + 1; i++) applyStimulus(1'b0, 1'b0, 4'h0);
      checkOutput("abort_pre_scl", scl, 1);
      checkOutput("abort_pre_sda", sda, 0);
      d0 = dones;
      applyStimulus(1'b1, 1'b1, 4'hF);
      checkOutput("abort_scl",  scl,  1);
      checkOutput("abort_sda",  sda,  1);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_rdy",  rdy,  1);
      applyStimulus(1'b0, 1'b1, 4'h6);
      checkOutput("abort_reaccept_busy", busy, 1);
      for (int i = 0; i < FRAME + 2; i++) applyStimulus(1'b0, 1'b0, 4'h0);
      checkOutput("abort_no_extra_done", dones - d0, 1);
      checkOutput("abort_next_word", lastRx, 4'h6);

`ifdef P2S_TXBUF_EN
      s0 = starts; d0 = dones;
      applyStimulus(1'b0, 1'b1, 4'h3);
      applyStimulus(1'b0, 1'b1, 4'hC);
      checkOutput("buf_full_rdy", rdy, 0);
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 4'h5);
      for (int i = 0; i < 2 * FRAME + 4; i++) applyStimulus(1'b0, 1'b0, 4'h0);
      checkOutput("buf_starts", starts - s0, 2);
      checkOutput("buf_dones",  dones - d0,  2);
      checkOutput("buf_first_word",  prevRx, 4'h3);
      checkOutput("buf_second_word", lastRx, 4'hC);
      checkOutput("buf_stop_to_start", lastGap, HALF);
`else
      s0 = starts; d0 = dones;
      applyStimulus(1'b0, 1'b1, 4'b1001);
      for (int i = 0; i < FRAME; i++) begin
         applyStimulus(1'b0, 1'b1, 4'(i));
         if (i == 10) checkOutput("hold_req_rdy", rdy, 0);
      end
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 4'h0);
      checkOutput("hold_req_starts", starts - s0, 1);
      checkOutput("hold_req_dones",  dones - d0,  1);
      checkOutput("hold_req_word",   lastRx, 4'b1001);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
